commit_stage: RTL
=================

Name: commit_stage

Overview:
- Consumes the ROB head (head_entry, head_ready) and retires one instruction per cycle.
- Non-store instructions: writes the architectural register file and clears the matching map-table entry.
- Stores: pushed into an internal FIFO store buffer that drains to data memory through a req/ack handshake. Loads probe this buffer for pending same-address stores.
- Asserts commit_stall back to the ROB. The ROB qualifies its head advance with !commit_stall.

Parameters:
SB_DEPTH, 4, store-buffer entries; power of two, >= 2
SB_PTR_LEN, $clog2(SB_DEPTH), FIFO pointer width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
head_entry  in  ROB_ENTRY  current ROB head entry
head_ready  in  1  head value and address ready
head_tag  in  `ROB_TAG_LEN  ROB tag of head
commit_stall  out  1  head must not retire this cycle
rf_wr_en  out  1  register file write enable
rf_wr_idx  out  5  destination register
rf_wr_data  out  `XLEN  write data
map_clear_en  out  1  clear map-table entry if it still holds map_clear_tag
map_clear_idx  out  5  register to clear
map_clear_tag  out  `ROB_TAG_LEN  retiring tag
mem_wr_req  out  1  store request to memory
mem_wr_addr  out  `XLEN  store address
mem_wr_data  out  `XLEN  store data
mem_wr_size  out  3  mem_size of the store
mem_wr_ack  in  1  memory accepted the request
ld_check_valid  in  1  load probe valid
ld_check_addr  in  `XLEN  load address
sb_addr_match  out  1  a buffered store has ld_check_addr
sb_empty  out  1  store buffer empty and no request in flight
retire_count  out  32  instructions retired since reset

Behaviour:
- Retire condition: retire = head_entry.valid && head_ready && !commit_stall. All commit outputs are combinational in the retire cycle; there is no added latency.
- Stall rule: commit_stall = head_entry.valid && head_ready && head_entry.wr_mem && sb_count == SB_DEPTH.
  - A pop in the same cycle does not release the stall. This is a conservative rule with no same-cycle bypass.
- Non-store retire:
  - rf_wr_en = 1 only when dest_reg != 0 (ZERO_REG is never written).
  - rf_wr_idx = dest_reg; rf_wr_data = head_entry.value.
  - map_clear_en = 1 under the same dest_reg != 0 condition; map_clear_tag = head_tag.
- Store retire:
  - No rf or map write.
  - Enqueue {dest_addr, value, mem_size} at the tail on the clock edge; tail advances mod SB_DEPTH and sb_count increments.
- Drain FSM, states SB_IDLE and SB_WAIT:
  - SB_IDLE -> SB_WAIT when sb_count > 0 at the clock edge. A fresh enqueue therefore reaches memory no earlier than the following cycle.
  - SB_WAIT: mem_wr_req = 1, with addr/data/size taken from the FIFO head and held stable until ack.
  - mem_wr_ack in SB_WAIT pops the head, decrements sb_count, and returns to SB_IDLE. There is always one idle cycle between consecutive stores.
  - mem_wr_ack outside SB_WAIT is ignored.
- Simultaneous enqueue and pop: sb_count is unchanged and both pointers advance.
- Count, pointers and ack:
  - sb_count is SB_PTR_LEN+1 bits wide.
  - Head and tail pointers wrap to 0 after SB_DEPTH-1.
- sb_addr_match = ld_check_valid && (any occupied entry has addr == ld_check_addr). It is combinational and exact full-XLEN compare; size is ignored. The entry currently in SB_WAIT counts until popped.
- sb_empty = (sb_count == 0) && state == SB_IDLE.
- retire_count: +1 per retire cycle, 32-bit wrapping.
- Reset (synchronous, any cycle, including mid-SB_WAIT):
  - FIFO emptied, pointers 0, state SB_IDLE, retire_count 0.
  - All outputs 0 except sb_empty = 1.
  - Any in-flight request is abandoned; a late ack is ignored.

Optional Feature:
- Macro: STORE_FORWARD_EN.
- When defined:
  - Adds outputs sb_fwd_valid (1) and sb_fwd_data (`XLEN).
  - sb_fwd_valid = 1 when the youngest matching entry has mem_size == word (3'b010); sb_fwd_data = that entry's data.
  - Youngest means the closest-to-tail search, wrapping.
  - Sub-word matches give sb_addr_match = 1 and sb_fwd_valid = 0.
- When undefined: the ports are absent and the load must wait for sb_addr_match to drop.

Decomposition:
- Shared package (sys_defs): ROB_ENTRY, `XLEN, `ROB_TAG_LEN, ZERO_REG, mem_size encodings, and a new SB_ENTRY typedef {addr, data, size}.
- Sub-module store_buffer: FIFO storage, drain FSM, address match and forwarding.
- commit_stage: retire decode, stall logic and retire_count.

Test Plan:
- ALU retire, dest x5, value 0x1234, head_tag 2 -> same cycle rf_wr_en=1, idx 5, data 0x1234; map_clear_en=1, tag 2; retire_count 0->1.
- Retire with dest x0 -> rf_wr_en=0, map_clear_en=0, retire_count still increments.
- Store addr 0x100 data 0xAB size word -> next cycle mem_wr_req=1 with 0x100/0xAB. Hold ack low for 3 cycles: outputs stable. Ack -> pop; sb_empty=1 the following cycle.
- Five stores back-to-back with ack low, SB_DEPTH=4 -> commit_stall=1 on the fifth while head_ready. Ack -> stall clears the cycle after pop; fifth store enqueued.
- Buffered store 0x200 plus ld_check 0x200 -> sb_addr_match=1; probe 0x204 -> 0. With STORE_FORWARD_EN, two word stores to 0x200 (0x1 then 0x2) -> sb_fwd_data=0x2.
- Reset asserted during SB_WAIT, ack arrives the cycle after -> mem_wr_req=0, sb_empty=1, retire_count=0, ack ignored.

Source files
------------

// File: rtl/sys_defs.sv
// sys_defs: shared types for the commit stage and its store buffer.
//   ROB_ENTRY  - the ROB head entry presented to commit.
//   SB_ENTRY   - one buffered store {addr, data, size}.
//   sb_state_e - drain FSM states of the store buffer.
//   XLEN and ROB_TAG_LEN are text macros so that callers may override them
//   on the command line. Each file guards its own default definition.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

package sys_defs;

  localparam logic [4:0] ZERO_REG = 5'd0;

  // mem_size encodings
  localparam logic [2:0] MEM_BYTE   = 3'b000;
  localparam logic [2:0] MEM_HALF   = 3'b001;
  localparam logic [2:0] MEM_WORD   = 3'b010;
  localparam logic [2:0] MEM_DOUBLE = 3'b011;

  typedef struct packed {
    logic              valid;
    logic              wr_mem;     // instruction is a store
    logic [4:0]        dest_reg;
    logic [`XLEN-1:0]  value;      // result, or store data for stores
    logic [`XLEN-1:0]  dest_addr;  // store address
    logic [2:0]        mem_size;
  } ROB_ENTRY;

  typedef struct packed {
    logic [`XLEN-1:0]  addr;
    logic [`XLEN-1:0]  data;
    logic [2:0]        size;
  } SB_ENTRY;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_WAIT = 1'b1
  } sb_state_e;

endpackage

// File: rtl/store_buffer.sv
// store_buffer: FIFO of retired stores draining to data memory.
//   Optional macro: STORE_FORWARD_EN adds fwd_valid_o / fwd_data_o.
// Ports:
//   clock, reset           - clock, synchronous active-high reset
//   push_i, push_entry_i   - enqueue one store at the tail (never while full)
//   mem_wr_req_o/addr/data/size, mem_wr_ack_i - drain handshake
//   ld_check_valid_i/addr_i, addr_match_o      - load probe
//   full_o, count_zero_o, state_o              - status / debug
//
// Drain handshake: mem_wr_req_o is high exactly while the FSM is in SB_WAIT,
// and addr/data/size come from the FIFO head, which only moves on a pop, so
// they are stable until acknowledged. A cycle with req and ack both high
// transfers the head entry and the FSM returns to SB_IDLE, leaving one idle
// cycle before the next request. Ack outside SB_WAIT has no effect. The
// request outputs are driven to zero while no request is pending.
`ifndef XLEN
`define XLEN 32
`endif

module store_buffer
  import sys_defs::*;
#(
  parameter int SB_DEPTH   = 4,
  parameter int SB_PTR_LEN = $clog2(SB_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  SB_ENTRY           push_entry_i,
  input  logic              mem_wr_ack_i,
  input  logic              ld_check_valid_i,
  input  logic [`XLEN-1:0]  ld_check_addr_i,
  output logic              mem_wr_req_o,
  output logic [`XLEN-1:0]  mem_wr_addr_o,
  output logic [`XLEN-1:0]  mem_wr_data_o,
  output logic [2:0]        mem_wr_size_o,
  output logic              addr_match_o,
`ifdef STORE_FORWARD_EN
  output logic              fwd_valid_o,
  output logic [`XLEN-1:0]  fwd_data_o,
`endif
  output logic              full_o,
  output logic              count_zero_o,
  output sb_state_e         state_o
);

  localparam logic [SB_PTR_LEN:0] SB_FULL = (SB_PTR_LEN+1)'(SB_DEPTH);

  SB_ENTRY                mem_q [SB_DEPTH];
  logic [SB_PTR_LEN-1:0]  head_q, head_d;
  logic [SB_PTR_LEN-1:0]  tail_q, tail_d;
  logic [SB_PTR_LEN:0]    count_q, count_d;
  sb_state_e              state_q, state_d;
  logic                   pop;
  SB_ENTRY                head_ent;

  // Next-state: drain FSM plus pointer/count bookkeeping.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pop     = 1'b0;
    case (state_q)
      // A push this cycle already counts, so a fresh store is requested
      // in the cycle right after it retires.
      SB_IDLE: if (count_q != '0 || push_i) state_d = SB_WAIT;
      SB_WAIT: if (mem_wr_ack_i) begin
        pop     = 1'b1;
        state_d = SB_IDLE;
      end
      default: state_d = SB_IDLE;
    endcase
    if (push_i) tail_d = tail_q + SB_PTR_LEN'(1);
    if (pop)    head_d = head_q + SB_PTR_LEN'(1);
    case ({push_i, pop})
      2'b10:   count_d = count_q + (SB_PTR_LEN+1)'(1);
      2'b01:   count_d = count_q - (SB_PTR_LEN+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SB_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy is defined by head/count alone.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[tail_q] <= push_entry_i;
  end

  assign head_ent      = mem_q[head_q];
  assign mem_wr_req_o  = (state_q == SB_WAIT);
  assign mem_wr_addr_o = mem_wr_req_o ? head_ent.addr : '0;
  assign mem_wr_data_o = mem_wr_req_o ? head_ent.data : '0;
  assign mem_wr_size_o = mem_wr_req_o ? head_ent.size : '0;
  assign full_o        = (count_q == SB_FULL);
  assign count_zero_o  = (count_q == '0);
  assign state_o       = state_q;

  // Walk from oldest to youngest; a later hit overrides an earlier one, so
  // the surviving hit is the youngest matching entry. Slot k (offset from
  // head) is occupied when k < count.
  logic [SB_PTR_LEN-1:0] slot;
  logic                  any_hit;
`ifdef STORE_FORWARD_EN
  SB_ENTRY               hit_ent;
`endif

  always_comb begin
    slot    = '0;
    any_hit = 1'b0;
`ifdef STORE_FORWARD_EN
    hit_ent = '0;
`endif
    for (int k = 0; k < SB_DEPTH; k++) begin
      slot = head_q + SB_PTR_LEN'(k);
      if (((SB_PTR_LEN+1)'(k) < count_q) && (mem_q[slot].addr == ld_check_addr_i)) begin
        any_hit = 1'b1;
`ifdef STORE_FORWARD_EN
        hit_ent = mem_q[slot];
`endif
      end
    end
  end

  assign addr_match_o = ld_check_valid_i && any_hit;

`ifdef STORE_FORWARD_EN
  // Only a full-word youngest match can supply the load's data.
  assign fwd_valid_o = addr_match_o && (hit_ent.size == MEM_WORD);
  assign fwd_data_o  = fwd_valid_o ? hit_ent.data : '0;
`endif

endmodule

// File: rtl/commit_stage.sv
// commit_stage: retires the ROB head, one instruction per cycle.
//   Optional macro: STORE_FORWARD_EN adds sb_fwd_valid / sb_fwd_data.
// Ports:
//   clock, reset                        - clock, synchronous active-high reset
//   head_entry, head_ready, head_tag    - ROB head
//   commit_stall                        - head may not retire this cycle
//   rf_wr_en/idx/data                   - architectural register write
//   map_clear_en/idx/tag                - map-table clear for the retiring tag
//   mem_wr_req/addr/data/size, mem_wr_ack - store drain to memory
//   ld_check_valid/addr, sb_addr_match  - load probe of pending stores
//   sb_empty                            - no buffered or in-flight store
//   retire_count                        - retired instructions since reset
// All commit outputs are combinational in the retire cycle.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

module commit_stage
  import sys_defs::*;
#(
  parameter int SB_DEPTH   = 4,
  parameter int SB_PTR_LEN = $clog2(SB_DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  ROB_ENTRY                 head_entry,
  input  logic                     head_ready,
  input  logic [`ROB_TAG_LEN-1:0]  head_tag,
  output logic                     commit_stall,
  output logic                     rf_wr_en,
  output logic [4:0]               rf_wr_idx,
  output logic [`XLEN-1:0]         rf_wr_data,
  output logic                     map_clear_en,
  output logic [4:0]               map_clear_idx,
  output logic [`ROB_TAG_LEN-1:0]  map_clear_tag,
  output logic                     mem_wr_req,
  output logic [`XLEN-1:0]         mem_wr_addr,
  output logic [`XLEN-1:0]         mem_wr_data,
  output logic [2:0]               mem_wr_size,
  input  logic                     mem_wr_ack,
  input  logic                     ld_check_valid,
  input  logic [`XLEN-1:0]         ld_check_addr,
  output logic                     sb_addr_match,
`ifdef STORE_FORWARD_EN
  output logic                     sb_fwd_valid,
  output logic [`XLEN-1:0]         sb_fwd_data,
`endif
  output logic                     sb_empty,
  output logic [31:0]              retire_count
);

  logic       head_live;
  logic       retire;
  logic       writes_reg;
  logic       sb_push;
  logic       sb_full;
  logic       sb_count_zero;
  sb_state_e  sb_state;
  SB_ENTRY    sb_push_entry;
  logic [31:0] retire_count_q, retire_count_d;

  assign head_live = head_entry.valid && head_ready;

  // Stall on a full buffer even if a pop happens this cycle: there is no
  // same-cycle bypass from the drain side into the enqueue side.
  assign commit_stall = head_live && head_entry.wr_mem && sb_full;
  assign retire       = head_live && !commit_stall;

  assign writes_reg    = retire && !head_entry.wr_mem && (head_entry.dest_reg != ZERO_REG);
  assign rf_wr_en      = writes_reg;
  assign rf_wr_idx     = writes_reg ? head_entry.dest_reg : '0;
  assign rf_wr_data    = writes_reg ? head_entry.value : '0;
  assign map_clear_en  = writes_reg;
  assign map_clear_idx = writes_reg ? head_entry.dest_reg : '0;
  assign map_clear_tag = writes_reg ? head_tag : '0;

  assign sb_push       = retire && head_entry.wr_mem;
  assign sb_push_entry = '{addr: head_entry.dest_addr,
                           data: head_entry.value,
                           size: head_entry.mem_size};

  assign retire_count_d = retire ? retire_count_q + 32'd1 : retire_count_q;

  always_ff @(posedge clock) begin
    if (reset) retire_count_q <= '0;
    else       retire_count_q <= retire_count_d;
  end

  assign retire_count = retire_count_q;
  assign sb_empty     = sb_count_zero && (sb_state == SB_IDLE);

  store_buffer #(
    .SB_DEPTH   (SB_DEPTH),
    .SB_PTR_LEN (SB_PTR_LEN)
  ) u_store_buffer (
    .clock            (clock),
    .reset            (reset),
    .push_i           (sb_push),
    .push_entry_i     (sb_push_entry),
    .mem_wr_ack_i     (mem_wr_ack),
    .ld_check_valid_i (ld_check_valid),
    .ld_check_addr_i  (ld_check_addr),
    .mem_wr_req_o     (mem_wr_req),
    .mem_wr_addr_o    (mem_wr_addr),
    .mem_wr_data_o    (mem_wr_data),
    .mem_wr_size_o    (mem_wr_size),
    .addr_match_o     (sb_addr_match),
`ifdef STORE_FORWARD_EN
    .fwd_valid_o      (sb_fwd_valid),
    .fwd_data_o       (sb_fwd_data),
`endif
    .full_o           (sb_full),
    .count_zero_o     (sb_count_zero),
    .state_o          (sb_state)
  );

endmodule
